// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: opcode/memory handshake inputs and datapath control outputs of the multi-cycle sequencer.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       trap;
  logic [3:0] state;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, trap, state
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, trap, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle fetch/decode/execute/memory/writeback sequencer with Moore datapath controls and memory wait-state timeout.
module mc_ctrl_fsm #(
  parameter int TO_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_RD = 4'd4, MEM_WB = 4'd5,
    MEM_WR = 4'd6, EXEC = 4'd7, R_WB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, ADDI_EX = 4'd11,
    ADDI_WB = 4'd12, TRAP = 4'd15
  } state_t;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(MEM_TIMEOUT - 1);
  state_t stateQ, stateD;
  logic [TO_WIDTH-1:0] toCnt, toCntD;
  logic waitSt, toFire, jal;
  logic [5:0] op;
  assign op     = bus.opcode;
  assign jal    = op == 6'h03;
  assign waitSt = stateQ inside {FETCH, MEM_RD, MEM_WR};
  // mem_ready has priority: a completing transfer never times out
  assign toFire = (MEM_TIMEOUT != 0) && toCnt == TO_LAST && !bus.mem_ready;
  assign toCntD = (waitSt && !bus.mem_ready && stateD == stateQ) ? ((&toCnt) ? toCnt : toCnt + 1'b1) : '0;
  assign bus.state = stateQ;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stateQ <= IDLE;
      toCnt  <= '0;
    end else begin
      stateQ <= stateD;
      toCnt  <= toCntD;
    end
  always_comb begin
    stateD            = stateQ;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;
    bus.trap          = 1'b0;
    case (stateQ)
      IDLE: stateD = FETCH;
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        stateD        = bus.mem_ready ? DECODE : toFire ? TRAP : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        stateD = op == 6'h00 ? EXEC :
                 (op == 6'h23 || op == 6'h2B) ? MEM_ADDR :
                 op == 6'h04 ? BRANCH :
                 (op == 6'h02 || jal) ? JUMP :
                 op == 6'h08 ? ADDI_EX : TRAP;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        stateD        = op == 6'h2B ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        stateD       = bus.mem_ready ? MEM_WB : toFire ? TRAP : MEM_RD;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
        bus.instr_done = 1'b1;
        stateD         = FETCH;
      end
      MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
        stateD         = bus.mem_ready ? FETCH : toFire ? TRAP : MEM_WR;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        stateD        = R_WB;
      end
      R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b01;
        bus.instr_done = 1'b1;
        stateD         = FETCH;
      end
      ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
        stateD        = ADDI_WB;
      end
      ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        stateD         = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
        stateD            = FETCH;
      end
      JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
        bus.reg_write  = jal;
        bus.reg_dst    = jal ? 2'b10 : 2'b00;
        bus.mem_to_reg = jal ? 2'b10 : 2'b00;
        stateD         = FETCH;
      end
      TRAP: bus.trap = 1'b1;
      default: stateD = TRAP;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized instruction streams against a per-instruction trace model of the sequencer.
module tb_mc_ctrl_fsm;
  localparam int TO = 4;
  localparam logic [3:0] S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3, S_MRD = 4, S_MWB = 5,
    S_MWR = 6, S_EXEC = 7, S_RWB = 8, S_BR = 9, S_JMP = 10, S_AEX = 11, S_AWB = 12, S_TRAP = 15;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       trap;
  } ctrl_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nChecks = 0;
  int nFails = 0;
  ctrl_t got;
  mc_ctrl_if bus();
  mc_ctrl_fsm #(.TO_WIDTH(8), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  assign got = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.instr_done, bus.trap};
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic [3:0] es, input ctrl_t ec, input logic rdy, input logic [5:0] op);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.opcode = op;
    #1;
    checkVal("state", 32'(bus.state), 32'(es));
    checkVal("ctrl", 32'(got), 32'(ec));
  endtask
  task automatic pulseReset;
    rst_n = 1'b0;
    #1;
    checkVal("rst_state", 32'(bus.state), 32'(S_IDLE));
    checkVal("rst_ctrl", 32'(got), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkVal("idle_state", 32'(bus.state), 32'(S_IDLE));
    checkVal("idle_ctrl", 32'(got), 32'd0);
  endtask
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
    ctrl_t e;
    bit trapped = 0;
    bit isLw;
    for (int i = 0; i < fw && i < TO; i++) begin
      e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
      step(S_FETCH, e, 1'b0, 6'($urandom));
    end
    if (fw >= TO) trapped = 1;
    else begin
      e = '0; e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1;
      step(S_FETCH, e, 1'b1, 6'($urandom));
      e = '0; e.alu_src_b = 2'b11;
      step(S_DECODE, e, 1'($urandom), op);
      if (op == 6'h00) begin
        e = '0; e.alu_src_a = 1; e.alu_op = 2'b10;
        step(S_EXEC, e, 1'($urandom), op);
        e = '0; e.reg_write = 1; e.reg_dst = 2'b01; e.instr_done = 1;
        step(S_RWB, e, 1'($urandom), op);
      end else if (op == 6'h23 || op == 6'h2B) begin
        isLw = op == 6'h23;
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
        step(S_MADDR, e, 1'($urandom), op);
        for (int i = 0; i < mw && i < TO; i++) begin
          e = '0; e.i_or_d = 1; e.mem_read = isLw; e.mem_write = !isLw;
          step(isLw ? S_MRD : S_MWR, e, 1'b0, op);
        end
        if (mw >= TO) trapped = 1;
        else begin
          e = '0; e.i_or_d = 1; e.mem_read = isLw; e.mem_write = !isLw; e.instr_done = !isLw;
          step(isLw ? S_MRD : S_MWR, e, 1'b1, op);
          if (isLw) begin
            e = '0; e.reg_write = 1; e.mem_to_reg = 2'b01; e.instr_done = 1;
            step(S_MWB, e, 1'($urandom), op);
          end
        end
      end else if (op == 6'h04) begin
        e = '0; e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; e.instr_done = 1;
        step(S_BR, e, 1'($urandom), op);
      end else if (op == 6'h02 || op == 6'h03) begin
        e = '0; e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1;
        if (op == 6'h03) begin e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
        step(S_JMP, e, 1'($urandom), op);
      end else if (op == 6'h08) begin
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
        step(S_AEX, e, 1'($urandom), op);
        e = '0; e.reg_write = 1; e.instr_done = 1;
        step(S_AWB, e, 1'($urandom), op);
      end else trapped = 1;
    end
    if (trapped) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.trap = 1;
        step(S_TRAP, e, 1'($urandom), 6'($urandom));
      end
      @(negedge clk);
      #1;
      pulseReset();
    end
  endtask
  function automatic logic [5:0] pickOp();
    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08};
    return ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
  endfunction
  function automatic int pickWait();
    return ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
  endfunction
  initial begin
    ctrl_t e;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'h00;
    @(negedge clk);
    #1;
    pulseReset();
    runInstr(6'h23, 0, 0);
    runInstr(6'h00, 3, 0);
    runInstr(6'h04, 0, 0);
    runInstr(6'h03, 1, 0);
    runInstr(6'h02, 0, 0);
    runInstr(6'h08, 2, 0);
    runInstr(6'h2B, 0, 2);
    runInstr(6'h23, 0, 3);
    runInstr(6'h2B, 0, TO + 1);
    runInstr(6'h3F, 0, 0);
    runInstr(6'h23, TO, 0);
    e = '0; e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1;
    step(S_FETCH, e, 1'b1, 6'h2B);
    e = '0; e.alu_src_b = 2'b11;
    step(S_DECODE, e, 1'b0, 6'h2B);
    e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
    step(S_MADDR, e, 1'b0, 6'h2B);
    e = '0; e.i_or_d = 1; e.mem_write = 1;
    step(S_MWR, e, 1'b0, 6'h2B);
    #2;
    pulseReset();
    for (int n = 0; n < 200; n++) runInstr(pickOp(), pickWait(), pickWait());
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle sequencer that replaces the single-cycle control decoder. It steps each instruction through fetch, decode, execute, memory and writeback states, and it can share one memory port between instruction and data access. It drives Moore-style datapath controls and handles a variable-latency memory handshake with a wait-state timeout. It sits between the instruction register opcode/funct fields and the PC, register file, ALU control and unified memory.

Parameters:
TO_WIDTH, 8, width of the memory wait-state timeout counter.
MEM_TIMEOUT, 200, number of consecutive wait cycles before entering TRAP; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
reg_write  output  1  register file write enable
reg_dst  output  2  00=rt, 01=rd, 10=$31
mem_to_reg  output  2  00=ALUOut, 01=MDR, 10=PC
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=sext imm, 11=sext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct, 11=add (addi)
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
trap  output  1  high while in TRAP
state  output  4  current state encoding, for debug

Behaviour:
- Reset: while rst_n=0, state=IDLE(0), timeout counter=0, all outputs 0. Reset is asynchronous and takes effect mid-instruction with no pending writes. After release, IDLE goes to FETCH on the next edge.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12, TRAP 15.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC
  - 0x23 (lw) or 0x2B (sw) → MEM_ADDR
  - 0x04 (beq) → BRANCH
  - 0x02 (j) or 0x03 (jal) → JUMP
  - 0x08 (addi) → ADDI_EX
  - anything else → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready. instr_done=mem_ready. Then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next is FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11. Next is ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next is FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. For jal only (opcode 0x03), also reg_write=1, reg_dst=10, mem_to_reg=10; the PC value written is the already-incremented PC+4. Next is FETCH.
- Wait states are FETCH, MEM_RD and MEM_WR.
- Timeout counter:
  - increments each cycle in a wait state with mem_ready=0;
  - clears on mem_ready=1 or on leaving the wait state;
  - when MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 with mem_ready=0, next state is TRAP;
  - the counter saturates and never wraps.
- If mem_ready=1 in the same cycle the timeout fires, mem_ready wins and the transfer completes.
- TRAP: trap=1, all other outputs 0. TRAP is left only through reset.
- mem_read and mem_write are never high together. mem_ready outside wait states is ignored.

Test Plan:
- lw (opcode 0x23), mem_ready tied 1 → states 1,2,3,4,5,1; reg_write=1 with mem_to_reg=01 exactly in cycle 5; exactly one instr_done pulse.
- R-type with mem_ready low for 3 cycles in FETCH → FETCH held 4 cycles; ir_write/pc_write high only in the 4th; then 2,7,8; reg_dst=01.
- beq then jal → BRANCH shows pc_write_cond=1, alu_op=01; JUMP shows pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- sw with MEM_TIMEOUT=4 and mem_ready held 0 → MEM_WR for 4 cycles, then state=15, trap=1; trap persists until rst_n pulses low, then IDLE → FETCH.
- Opcode 0x3F → DECODE then TRAP; no reg_write or mem_write asserted at any point.
- rst_n driven low asynchronously mid-MEM_WR → outputs go 0 immediately without a clock edge; after release, IDLE for one cycle, then FETCH.
